// File: rtl/enemy_shot_scheduler.sv
// Enemy shot scheduler: grants biker shoot requests round-robin onto a small
// pool of bullet slots, one shot per cooldown window, aligned to frame starts.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a frame start to attempt arbitration
// ARB      | one cycle: pick round-robin winner and lowest free slot
// ISSUE    | one cycle: fireValid high, cooldown counter loaded
// COOLDOWN | counting frame starts down; the expiring frame arbitrates
module enemy_shot_scheduler #(
    parameter int ENEMY_BIKERS_COUNT = 8,
    parameter int BULLET_SLOTS       = 4,
    parameter int BASE_COOLDOWN      = 12,
    parameter int MIN_COOLDOWN       = 2,
    parameter int SPAWN_DX           = 14,
    parameter int SPAWN_DY           = 32
) (
    input  logic                                  clk,
    input  logic                                  resetN,
    input  logic                                  startOfFrame,
    input  logic                                  startOfLevel,
    input  logic [3:0]                            level,
    input  logic [ENEMY_BIKERS_COUNT-1:0]         shootRequest,
    input  logic [ENEMY_BIKERS_COUNT-1:0][10:0]   bikersX,
    input  logic [ENEMY_BIKERS_COUNT-1:0][10:0]   bikersY,
    input  logic [BULLET_SLOTS-1:0]               slotDone,
    output logic                                  fireValid,
    output logic [$clog2(BULLET_SLOTS)-1:0]       fireSlot,
    output logic [$clog2(ENEMY_BIKERS_COUNT)-1:0] fireBiker,
    output logic [10:0]                           fireX,
    output logic [10:0]                           fireY,
    output logic [BULLET_SLOTS-1:0]               slotBusy
);

    localparam int N      = ENEMY_BIKERS_COUNT;
    localparam int S      = BULLET_SLOTS;
    localparam int SW     = $clog2(S);
    localparam int BW     = $clog2(N);
    localparam int CD_MAX = (BASE_COOLDOWN > MIN_COOLDOWN) ? BASE_COOLDOWN : MIN_COOLDOWN;
    localparam int CW     = $clog2(CD_MAX + 1);

    typedef enum logic [1:0] {IDLE, ARB, ISSUE, COOLDOWN} state_t;

    state_t        state;
    logic [N-1:0]  pending;
    logic [S-1:0]  slot_busy;
    logic [BW-1:0] rr_ptr;
    logic [CW-1:0] cd;
    logic          fire_valid_r;

    logic          win_found;
    logic [BW-1:0] win_idx;
    int            scan_idx;
    logic          slot_found;
    logic [SW-1:0] slot_idx;
    logic          grant;
    logic [N-1:0]  grant_mask;
    logic [S-1:0]  alloc_mask;
    int            cd_raw;
    logic [CW-1:0] cd_load;
    logic [10:0]   spawn_x;
    logic [10:0]   spawn_y;

    // Round-robin winner: scan downwards so the last hit is the one nearest rr_ptr+1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = N; k >= 1; k--) begin
            scan_idx = (int'(rr_ptr) + k) % N;
            if (pending[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = BW'(scan_idx);
            end
        end
    end

    // Lowest-index free slot, again by descending overwrite.
    always_comb begin
        slot_found = 1'b0;
        slot_idx   = '0;
        for (int s = S - 1; s >= 0; s--) begin
            if (!slot_busy[s]) begin
                slot_found = 1'b1;
                slot_idx   = SW'(s);
            end
        end
    end

    // Grant decode, spawn point and level-dependent cooldown (signed, clamped).
    always_comb begin
        grant      = (state == ARB) && win_found && slot_found;
        grant_mask = '0;
        alloc_mask = '0;
        if (grant) begin
            grant_mask[win_idx]  = 1'b1;
            alloc_mask[slot_idx] = 1'b1;
        end
        spawn_x = bikersX[win_idx] + 11'(SPAWN_DX);
        spawn_y = bikersY[win_idx] + 11'(SPAWN_DY);
        cd_raw  = BASE_COOLDOWN - int'(level);
        if (cd_raw < MIN_COOLDOWN) cd_load = CW'(MIN_COOLDOWN);
        else                       cd_load = CW'(cd_raw);
    end

    // Scheduler FSM with its request latch, slot flags and registered fire outputs.
    // The frame start that takes the cooldown from 1 to 0 also starts arbitration,
    // so consecutive shots are exactly cd_load frames apart.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            pending      <= '0;
            slot_busy    <= '0;
            rr_ptr       <= BW'(N - 1);
            cd           <= '0;
            fire_valid_r <= 1'b0;
            fireSlot     <= '0;
            fireBiker    <= '0;
            fireX        <= '0;
            fireY        <= '0;
        end else if (startOfLevel) begin
            state        <= IDLE;
            pending      <= '0;
            slot_busy    <= '0;
            rr_ptr       <= BW'(N - 1);
            cd           <= '0;
            fire_valid_r <= 1'b0;
        end else begin
            pending      <= (pending & ~grant_mask) | shootRequest;
            slot_busy    <= (slot_busy & ~slotDone) | alloc_mask;
            fire_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (startOfFrame) state <= ARB;
                end
                ARB: begin
                    if (grant) begin
                        fireSlot     <= slot_idx;
                        fireBiker    <= win_idx;
                        fireX        <= spawn_x;
                        fireY        <= spawn_y;
                        rr_ptr       <= win_idx;
                        fire_valid_r <= 1'b1;
                        state        <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    cd    <= cd_load;
                    state <= COOLDOWN;
                end
                COOLDOWN: begin
                    if (cd == '0) begin
                        state <= IDLE;
                    end else if (startOfFrame) begin
                        cd <= cd - CW'(1);
                        if (cd == CW'(1)) state <= ARB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A level flush arriving during ISSUE suppresses the launch pulse immediately.
    assign fireValid = fire_valid_r & ~startOfLevel;
    assign slotBusy  = slot_busy;

endmodule

// File: tb/tb_enemy_shot_scheduler.sv
// Directed bench for enemy_shot_scheduler with hand-computed expectations.
module tb_enemy_shot_scheduler;

    localparam int N = 8;
    localparam int S = 4;

    logic                clk = 1'b0;
    logic                resetN = 1'b0;
    logic                startOfFrame = 1'b0;
    logic                startOfLevel = 1'b0;
    logic [3:0]          level = 4'd0;
    logic [N-1:0]        shootRequest = '0;
    logic [N-1:0][10:0]  bikersX;
    logic [N-1:0][10:0]  bikersY;
    logic [S-1:0]        slotDone = '0;
    logic                fireValid;
    logic [1:0]          fireSlot;
    logic [2:0]          fireBiker;
    logic [10:0]         fireX;
    logic [10:0]         fireY;
    logic [S-1:0]        slotBusy;

    int errors = 0;
    int checks = 0;
    int n;
    bit fired;

    enemy_shot_scheduler dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startOfLevel (startOfLevel),
        .level        (level),
        .shootRequest (shootRequest),
        .bikersX      (bikersX),
        .bikersY      (bikersY),
        .slotDone     (slotDone),
        .fireValid    (fireValid),
        .fireSlot     (fireSlot),
        .fireBiker    (fireBiker),
        .fireX        (fireX),
        .fireY        (fireY),
        .slotBusy     (slotBusy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_req(input logic [N-1:0] m);
        @(negedge clk); shootRequest = m;
        @(negedge clk); shootRequest = '0;
    endtask

    task automatic pulse_done(input logic [S-1:0] m);
        @(negedge clk); slotDone = m;
        @(negedge clk); slotDone = '0;
    endtask

    task automatic pulse_sol();
        @(negedge clk); startOfLevel = 1'b1;
        @(negedge clk); startOfLevel = 1'b0;
    endtask

    // One frame: a start-of-frame pulse followed by six quiet cycles.
    task automatic frame(output bit f);
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        f = 1'b0;
        repeat (6) begin
            if (fireValid === 1'b1) f = 1'b1;
            @(negedge clk);
        end
    endtask

    // Runs frames until a shot is seen or max_frames elapse.
    task automatic wait_fire(input int max_frames, output int nf, output bit fd);
        bit f;
        nf = 0;
        fd = 1'b0;
        while (!fd && nf < max_frames) begin
            frame(f);
            nf++;
            if (f) fd = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            bikersX[i] = 11'(i * 10 + 70);
            bikersY[i] = 11'(i * 20 + 140);
        end
        bikersX[7] = 11'd2040;
        bikersY[7] = 11'd2030;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_fireValid", 32'(fireValid), 0);
        chk("rst_fireSlot",  32'(fireSlot), 0);
        chk("rst_fireBiker", 32'(fireBiker), 0);
        chk("rst_fireX",     32'(fireX), 0);
        chk("rst_fireY",     32'(fireY), 0);
        chk("rst_slotBusy",  32'(slotBusy), 0);
        resetN = 1'b1;

        // T1: single request, latency
        pulse_req(8'h08);
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        chk("t1_no_fire_arb", 32'(fireValid), 0);
        @(negedge clk);
        chk("t1_fire",      32'(fireValid), 1);
        chk("t1_biker",     32'(fireBiker), 3);
        chk("t1_slot",      32'(fireSlot), 0);
        chk("t1_busy",      32'(slotBusy), 4'b0001);
        chk("t1_x",         32'(fireX), 114);
        chk("t1_y",         32'(fireY), 232);
        @(negedge clk);
        chk("t1_pulse_end", 32'(fireValid), 0);

        // T2: round-robin 3,5,1 with 12-frame spacing (rrPtr primed to 2)
        pulse_sol();
        chk("t2_flush_busy", 32'(slotBusy), 0);
        pulse_req(8'h04);
        wait_fire(2, n, fired);
        chk("t2_prime_n",     32'(n), 1);
        chk("t2_prime_biker", 32'(fireBiker), 2);
        pulse_req(8'h2A);
        wait_fire(14, n, fired);
        chk("t2_a_n",     32'(n), 12);
        chk("t2_a_biker", 32'(fireBiker), 3);
        chk("t2_a_slot",  32'(fireSlot), 1);
        chk("t2_a_x",     32'(fireX), 114);
        chk("t2_a_y",     32'(fireY), 232);
        wait_fire(14, n, fired);
        chk("t2_b_n",     32'(n), 12);
        chk("t2_b_biker", 32'(fireBiker), 5);
        chk("t2_b_slot",  32'(fireSlot), 2);
        chk("t2_b_x",     32'(fireX), 134);
        chk("t2_b_y",     32'(fireY), 272);
        wait_fire(14, n, fired);
        chk("t2_c_n",     32'(n), 12);
        chk("t2_c_biker", 32'(fireBiker), 1);
        chk("t2_c_slot",  32'(fireSlot), 3);
        chk("t2_c_x",     32'(fireX), 94);
        chk("t2_c_y",     32'(fireY), 192);
        chk("t2_all_busy", 32'(slotBusy), 4'b1111);

        // T3: all slots busy, then free slot 2
        pulse_req(8'h40);
        wait_fire(14, n, fired);
        chk("t3_no_fire", 32'(fired), 0);
        pulse_done(4'b0100);
        chk("t3_freed",    32'(slotBusy), 4'b1011);
        pulse_done(4'b0100);
        chk("t3_free_ign", 32'(slotBusy), 4'b1011);
        wait_fire(2, n, fired);
        chk("t3_n",     32'(n), 1);
        chk("t3_slot",  32'(fireSlot), 2);
        chk("t3_biker", 32'(fireBiker), 6);
        chk("t3_x",     32'(fireX), 144);
        chk("t3_y",     32'(fireY), 292);

        // T4: level 15 clamps to 2 frames, level 5 gives 7 frames; X/Y wrap
        pulse_sol();
        level = 4'd15;
        pulse_req(8'h11);
        wait_fire(2, n, fired);
        chk("t4_a_n",     32'(n), 1);
        chk("t4_a_biker", 32'(fireBiker), 0);
        wait_fire(5, n, fired);
        chk("t4_b_n",     32'(n), 2);
        chk("t4_b_biker", 32'(fireBiker), 4);
        chk("t4_b_slot",  32'(fireSlot), 1);
        level = 4'd5;
        pulse_req(8'h80);
        wait_fire(5, n, fired);
        chk("t4_c_n",     32'(n), 2);
        chk("t4_c_biker", 32'(fireBiker), 7);
        chk("t4_wrap_x",  32'(fireX), 6);
        chk("t4_wrap_y",  32'(fireY), 14);
        pulse_req(8'h01);
        wait_fire(10, n, fired);
        chk("t4_d_n",     32'(n), 7);
        chk("t4_d_biker", 32'(fireBiker), 0);
        chk("t4_d_slot",  32'(fireSlot), 3);

        // slotDone in the ARB cycle is not usable by that ARB
        pulse_req(8'h04);
        wait_fire(7, n, fired);
        chk("sd_arb_full", 32'(fired), 0);
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0; slotDone = 4'b0010;
        @(negedge clk); slotDone = '0;
        chk("sd_arb_nofire", 32'(fireValid), 0);
        chk("sd_arb_busy",   32'(slotBusy), 4'b1101);
        wait_fire(2, n, fired);
        chk("sd_next_n",     32'(n), 1);
        chk("sd_next_slot",  32'(fireSlot), 1);
        chk("sd_next_biker", 32'(fireBiker), 2);

        // T5: startOfLevel during ARB cancels the shot and clears pending
        pulse_sol();
        chk("t5_flush_busy", 32'(slotBusy), 0);
        pulse_req(8'h40);
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0; startOfLevel = 1'b1;
        @(negedge clk); startOfLevel = 1'b0;
        chk("t5_nofire", 32'(fireValid), 0);
        chk("t5_busy",   32'(slotBusy), 0);
        wait_fire(2, n, fired);
        chk("t5_pending_clr", 32'(fired), 0);
        pulse_req(8'h44);
        wait_fire(2, n, fired);
        chk("t5_n",     32'(n), 1);
        chk("t5_biker", 32'(fireBiker), 2);
        chk("t5_slot",  32'(fireSlot), 0);

        // startOfLevel in the ISSUE cycle suppresses fireValid
        pulse_sol();
        pulse_req(8'h20);
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0;
        @(negedge clk); startOfLevel = 1'b1;
        #1;
        chk("iss_cancel_fire", 32'(fireValid), 0);
        @(negedge clk); startOfLevel = 1'b0;
        chk("iss_cancel_busy", 32'(slotBusy), 0);
        wait_fire(2, n, fired);
        chk("iss_cancel_idle", 32'(fired), 0);

        // T6: request in the grant cycle keeps pending; served after a full pass
        pulse_req(8'h12);
        @(negedge clk); startOfFrame = 1'b1;
        @(negedge clk); startOfFrame = 1'b0; shootRequest = 8'h02;
        @(negedge clk); shootRequest = '0;
        chk("t6_fire",  32'(fireValid), 1);
        chk("t6_biker", 32'(fireBiker), 1);
        wait_fire(9, n, fired);
        chk("t6_b_n",     32'(n), 7);
        chk("t6_b_biker", 32'(fireBiker), 4);
        wait_fire(9, n, fired);
        chk("t6_c_n",     32'(n), 7);
        chk("t6_c_biker", 32'(fireBiker), 1);
        chk("t6_c_slot",  32'(fireSlot), 2);

        // Asynchronous reset mid-cooldown
        @(negedge clk); #2 resetN = 1'b0;
        #1;
        chk("arst_busy",  32'(slotBusy), 0);
        chk("arst_biker", 32'(fireBiker), 0);
        chk("arst_x",     32'(fireX), 0);
        @(negedge clk); resetN = 1'b1;
        pulse_req(8'h20);
        wait_fire(2, n, fired);
        chk("arst_after_n",     32'(n), 1);
        chk("arst_after_biker", 32'(fireBiker), 5);
        chk("arst_after_slot",  32'(fireSlot), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
